// File: rtl/rcn_pkg.sv
// Shared rcn ring packet layout and QSPI constants for the rcn_qspi block.
package rcn_pkg;

  // 69-bit ring packet: {valid, req, wr, id[5:0], mask[3:0], addr[23:2], seq[1:0], data[31:0]}
  localparam int unsigned RCN_W       = 69;
  localparam int unsigned RCN_VALID   = 68;
  localparam int unsigned RCN_REQ     = 67;
  localparam int unsigned RCN_WR      = 66;
  localparam int unsigned RCN_ID_HI   = 65;
  localparam int unsigned RCN_ID_LO   = 60;
  localparam int unsigned RCN_MASK_HI = 59;
  localparam int unsigned RCN_MASK_LO = 56;
  localparam int unsigned RCN_ADDR_HI = 55;
  localparam int unsigned RCN_ADDR_LO = 34;
  localparam int unsigned RCN_SEQ_HI  = 33;
  localparam int unsigned RCN_SEQ_LO  = 32;
  localparam int unsigned RCN_DATA_HI = 31;
  localparam int unsigned RCN_DATA_LO = 0;

  // Fast Read Quad Output
  localparam logic [7:0] QSPI_CMD_QREAD = 8'h6B;

  // Phase bit counts of one read transaction
  localparam logic [4:0] QSPI_CMD_BITS   = 5'd8;
  localparam logic [4:0] QSPI_ADDR_BITS  = 5'd24;
  localparam logic [4:0] QSPI_DUMMY_SCK  = 5'd8;
  localparam logic [4:0] QSPI_DATA_NIBS  = 5'd8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_GAP,
    ST_RESP
  } qspi_state_t;

  typedef enum logic {
    SH_SERIAL_OUT = 1'b0,
    SH_QUAD_IN    = 1'b1
  } shift_mode_t;

  // Flash bytes arrive in address order (byte A first); the ring word is little-endian.
  function automatic logic [31:0] le_word(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/rcn_qspi_shift.sv
// SCK divider plus serial-out / quad-in shifter for one QSPI phase.
// Outputs change on the SCK falling edge, input is sampled on the rising edge.
// A start coincident with done chains the next phase without an idle half-period.
module qspi_shift
  import rcn_pkg::*;
#(
  parameter logic [3:0] CLK_DIV = 4'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  shift_mode_t mode,
  input  logic [4:0]  count,
  input  logic [31:0] tx_data,
  output logic [31:0] rx_data,
  output logic        done,
  output logic        sck,
  output logic [3:0]  io_o,
  output logic [3:0]  io_oe,
  input  logic [3:0]  io_i
);

  localparam logic [3:0] HALF_LAST = CLK_DIV - 4'd1;

  shift_mode_t mode_q;
  logic        running;
  logic [3:0]  div_cnt;
  logic [4:0]  left;
  logic [31:0] tx_sr;
  logic        half_end;

  assign half_end = running && (div_cnt == HALF_LAST);
  // Combinational so the caller can start the next phase on this same falling edge
  assign done     = half_end && sck && (left == 5'd1);

  // Half-period timing, SCK generation, and the data shift registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= SH_SERIAL_OUT;
      running <= 1'b0;
      div_cnt <= '0;
      left    <= '0;
      tx_sr   <= '0;
      rx_data <= '0;
      sck     <= 1'b0;
      io_o    <= '0;
      io_oe   <= '0;
    end else if (start) begin
      running <= 1'b1;
      mode_q  <= mode;
      div_cnt <= '0;
      left    <= count;
      sck     <= 1'b0;
      tx_sr   <= tx_data;
      rx_data <= '0;
      if (mode == SH_SERIAL_OUT) begin
        io_o  <= {3'b000, tx_data[31]};
        io_oe <= 4'b0001;
      end else begin
        io_o  <= '0;
        io_oe <= '0;
      end
    end else if (half_end) begin
      div_cnt <= '0;
      if (!sck) begin
        sck <= 1'b1;
        if (mode_q == SH_QUAD_IN) begin
          rx_data <= {rx_data[27:0], io_i};
        end
      end else begin
        sck  <= 1'b0;
        left <= left - 5'd1;
        if (left == 5'd1) begin
          running <= 1'b0;
          io_o    <= '0;
          io_oe   <= '0;
        end else if (mode_q == SH_SERIAL_OUT) begin
          tx_sr   <= tx_sr << 1;
          io_o    <= {3'b000, tx_sr[30]};
        end
      end
    end else if (running) begin
      div_cnt <= div_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/rcn_qspi.sv
// Read-only QSPI flash slave on the rcn ring: one 32-bit Fast Read Quad
// Output per matching read, writes answered immediately with data=0,
// all other traffic forwarded with one register of latency.
module rcn_qspi
  import rcn_pkg::*;
#(
  parameter logic [23:0] ADDR_BASE = 24'hC00000,
  parameter logic [23:0] ADDR_MASK = 24'hC00000,
  parameter logic [3:0]  CLK_DIV   = 4'd2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RCN_W-1:0] rcn_in,
  output logic [RCN_W-1:0] rcn_out,
  output logic             qspi_clk,
  output logic             qspi_csn,
  output logic [3:0]       qspi_io_o,
  output logic [3:0]       qspi_io_oe,
  input  logic [3:0]       qspi_io_i,
  output logic             busy
);

  // csn stays high for 2*CLK_DIV cycles between the last SCK and the response
  localparam logic [4:0] GAP_LAST = {CLK_DIV, 1'b0} - 5'd1;

  qspi_state_t state;
  logic        go;
  logic [4:0]  gap_cnt;
  logic        req_wr;
  logic [5:0]  req_id;
  logic [3:0]  req_mask;
  logic [21:0] req_addr;
  logic [1:0]  req_seq;
  logic [31:0] rdata;

  logic [23:0]      in_byte_addr;
  logic             hit;
  logic [23:0]      flash_addr;
  logic [RCN_W-1:0] resp_pkt;

  logic        sh_start;
  shift_mode_t sh_mode;
  logic [4:0]  sh_count;
  logic [31:0] sh_tx;
  logic [31:0] sh_rx;
  logic        sh_done;

  assign in_byte_addr = {rcn_in[RCN_ADDR_HI:RCN_ADDR_LO], 2'b00};
  assign hit          = rcn_in[RCN_VALID] && rcn_in[RCN_REQ]
                        && ((in_byte_addr & ADDR_MASK) == ADDR_BASE);
  assign flash_addr   = {req_addr, 2'b00} & ~ADDR_MASK;
  assign resp_pkt     = {1'b1, 1'b0, req_wr, req_id, req_mask, req_addr, req_seq, rdata};

  // Phase launch: first phase one cycle after capture, later ones chained on done
  always_comb begin
    sh_start = 1'b0;
    sh_mode  = SH_SERIAL_OUT;
    sh_count = '0;
    sh_tx    = '0;
    unique case (state)
      ST_CMD: begin
        if (go) begin
          sh_start = 1'b1;
          sh_mode  = SH_SERIAL_OUT;
          sh_count = QSPI_CMD_BITS;
          sh_tx    = {QSPI_CMD_QREAD, 24'h000000};
        end else if (sh_done) begin
          sh_start = 1'b1;
          sh_mode  = SH_SERIAL_OUT;
          sh_count = QSPI_ADDR_BITS;
          sh_tx    = {flash_addr, 8'h00};
        end
      end
      ST_ADDR: begin
        if (sh_done) begin
          sh_start = 1'b1;
          sh_mode  = SH_QUAD_IN;
          sh_count = QSPI_DUMMY_SCK;
        end
      end
      ST_DUMMY: begin
        if (sh_done) begin
          sh_start = 1'b1;
          sh_mode  = SH_QUAD_IN;
          sh_count = QSPI_DATA_NIBS;
        end
      end
      default: ;
    endcase
  end

  qspi_shift #(
    .CLK_DIV (CLK_DIV)
  ) u_shift (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (sh_start),
    .mode    (sh_mode),
    .count   (sh_count),
    .tx_data (sh_tx),
    .rx_data (sh_rx),
    .done    (sh_done),
    .sck     (qspi_clk),
    .io_o    (qspi_io_o),
    .io_oe   (qspi_io_oe),
    .io_i    (qspi_io_i)
  );

  // Ring slot handling, request capture, and the transaction sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      go       <= 1'b0;
      gap_cnt  <= '0;
      busy     <= 1'b0;
      qspi_csn <= 1'b1;
      req_wr   <= 1'b0;
      req_id   <= '0;
      req_mask <= '0;
      req_addr <= '0;
      req_seq  <= '0;
      rdata    <= '0;
      rcn_out  <= '0;
    end else begin
      rcn_out <= rcn_in;
      unique case (state)
        ST_IDLE: begin
          if (hit) begin
            req_wr   <= rcn_in[RCN_WR];
            req_id   <= rcn_in[RCN_ID_HI:RCN_ID_LO];
            req_mask <= rcn_in[RCN_MASK_HI:RCN_MASK_LO];
            req_addr <= rcn_in[RCN_ADDR_HI:RCN_ADDR_LO];
            req_seq  <= rcn_in[RCN_SEQ_HI:RCN_SEQ_LO];
            rdata    <= '0;
            busy     <= 1'b1;
            rcn_out  <= '0;
            if (rcn_in[RCN_WR]) begin
              state <= ST_RESP;
            end else begin
              state <= ST_CMD;
              go    <= 1'b1;
            end
          end
        end
        ST_CMD: begin
          if (go) begin
            go       <= 1'b0;
            qspi_csn <= 1'b0;
          end else if (sh_done) begin
            state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (sh_done) state <= ST_DUMMY;
        end
        ST_DUMMY: begin
          if (sh_done) state <= ST_DATA;
        end
        ST_DATA: begin
          if (sh_done) begin
            rdata    <= le_word(sh_rx);
            qspi_csn <= 1'b1;
            gap_cnt  <= '0;
            state    <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= ST_RESP;
          end else begin
            gap_cnt <= gap_cnt + 5'd1;
          end
        end
        ST_RESP: begin
          // Only an empty slot takes the response; anything else passes through
          if (!rcn_in[RCN_VALID]) begin
            rcn_out <= resp_pkt;
            rcn_out[RCN_DATA_HI:RCN_DATA_LO] <= rdata;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rcn_qspi.sv
// Self-checking bench for rcn_qspi with a behavioural QSPI flash model.
module tb_rcn_qspi;

  localparam int D = 2;
  localparam logic [23:0] WMASK = 24'hC00000;
  localparam int RD_LAT = 98 * D + 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [68:0] rcn_in = '0;
  logic [68:0] rcn_out;
  logic        qspi_clk, qspi_csn, busy;
  logic [3:0]  qspi_io_o, qspi_io_oe;
  logic [3:0]  qspi_io_i = '0;

  int checks = 0;
  int failures = 0;

  rcn_qspi #(
    .ADDR_BASE (24'hC00000),
    .ADDR_MASK (24'hC00000),
    .CLK_DIV   (4'd2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rcn_in     (rcn_in),
    .rcn_out    (rcn_out),
    .qspi_clk   (qspi_clk),
    .qspi_csn   (qspi_csn),
    .qspi_io_o  (qspi_io_o),
    .qspi_io_oe (qspi_io_oe),
    .qspi_io_i  (qspi_io_i),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Flash contents: explicit bytes where written, otherwise an address pattern
  logic [7:0] flash_mem [logic [23:0]];

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    if (flash_mem.exists(a)) return flash_mem[a];
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  // Flash/bus monitor: SPI state seen by the flash
  int          rise_cnt = 0;
  int          spi_txn = 0;
  int          oe_err = 0;
  logic [31:0] spi_bits = '0;
  logic [7:0]  spi_cmd = '0;
  logic [23:0] spi_addr = '0;
  logic        csn_prev = 1'b1;
  logic        sck_prev = 1'b0;

  function automatic logic [3:0] nib(input int k);
    logic [7:0] b;
    b = flash_byte(spi_addr + 24'(k / 2));
    return (k % 2 == 0) ? b[7:4] : b[3:0];
  endfunction

  always @(negedge clk) begin
    if (qspi_csn) begin
      rise_cnt = 0;
    end else begin
      if (csn_prev) spi_txn++;
      if (qspi_clk && !sck_prev) begin
        rise_cnt++;
        if (rise_cnt <= 32) begin
          spi_bits = {spi_bits[30:0], qspi_io_o[0]};
          if (qspi_io_oe !== 4'b0001) oe_err++;
        end else if (qspi_io_oe !== 4'b0000) begin
          oe_err++;
        end
        if (rise_cnt == 32) begin
          spi_cmd  = spi_bits[31:24];
          spi_addr = spi_bits[23:0];
        end
      end
      if (!qspi_clk && sck_prev && rise_cnt >= 40 && rise_cnt < 48)
        qspi_io_i = nib(rise_cnt - 40);
    end
    csn_prev = qspi_csn;
    sck_prev = qspi_clk;
  end

  function automatic logic [68:0] mk(input logic req, input logic wr, input logic [5:0] id,
                                     input logic [3:0] mask, input logic [23:0] a,
                                     input logic [1:0] seq, input logic [31:0] d);
    return {1'b1, req, wr, id, mask, a[23:2], seq, d};
  endfunction

  // Expected response for a request the slave accepts
  function automatic logic [68:0] model(input logic [68:0] p);
    logic [23:0] fa;
    logic [31:0] d;
    fa = {p[55:34], 2'b00} & ~WMASK;
    if (p[66]) d = 32'h0;
    else d = {flash_byte(fa + 24'd3), flash_byte(fa + 24'd2), flash_byte(fa + 24'd1), flash_byte(fa)};
    return {1'b1, 1'b0, p[66:32], d};
  endfunction

  task automatic chk(input string tag, input logic [68:0] obs, input logic [68:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one packet for one cycle, then wait (bounded) for the next valid output
  task automatic do_txn(input logic [68:0] p, output int lat, output logic [68:0] got,
                        output logic [68:0] first_out, output logic first_busy);
    bit seen;
    @(posedge clk); #1 rcn_in = p;
    @(posedge clk); #1 rcn_in = '0;
    lat = 1;
    first_out = rcn_out;
    first_busy = busy;
    got = rcn_out;
    seen = rcn_out[68];
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(posedge clk); #1;
      lat++;
      got = rcn_out;
      seen = rcn_out[68];
    end
  endtask

  task automatic wait_resp(inout int lat, output logic [68:0] got);
    bit seen;
    seen = 1'b0;
    got = '0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(posedge clk); #1;
      lat++;
      got = rcn_out;
      seen = rcn_out[68];
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, t0, oe0;
    logic [68:0] p, q, got, fo, exp;
    logic        fb;
    logic [23:0] a;
    logic [68:0] traffic [5];

    flash_mem[24'h000010] = 8'h11;
    flash_mem[24'h000011] = 8'h22;
    flash_mem[24'h000012] = 8'h33;
    flash_mem[24'h000013] = 8'h44;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rcn_out", rcn_out, '0);
    chk("rst_sck", 69'(qspi_clk), 69'(0));
    chk("rst_csn", 69'(qspi_csn), 69'(1));
    chk("rst_io_o", 69'(qspi_io_o), 69'(0));
    chk("rst_io_oe", 69'(qspi_io_oe), 69'(0));
    chk("rst_busy", 69'(busy), 69'(0));
    @(negedge clk) rst_n = 1'b1;

    // Directed read at 0xC00010
    p = mk(1'b1, 1'b0, 6'($urandom_range(0, 63)), 4'hF, 24'hC00010, 2'($urandom_range(0, 3)), 32'($urandom));
    t0 = spi_txn; oe0 = oe_err;
    do_txn(p, lat, got, fo, fb);
    chk("rd1_resp", got, model(p));
    chk("rd1_data", 69'(got[31:0]), 69'(32'h44332211));
    chk("rd1_lat", 69'(lat), 69'(RD_LAT));
    chk("rd1_capture_slot", fo, '0);
    chk("rd1_busy_set", 69'(fb), 69'(1));
    chk("rd1_cmd", 69'(spi_cmd), 69'(8'h6B));
    chk("rd1_addr", 69'(spi_addr), 69'(24'h000010));
    chk("rd1_txn", 69'(spi_txn - t0), 69'(1));
    chk("rd1_oe", 69'(oe_err - oe0), 69'(0));
    chk("rd1_busy_clr", 69'(busy), 69'(0));

    // Write: immediate response, no bus activity
    p = mk(1'b1, 1'b1, 6'($urandom_range(0, 63)), 4'h3, 24'hC00020, 2'($urandom_range(0, 3)), 32'($urandom));
    t0 = spi_txn;
    do_txn(p, lat, got, fo, fb);
    chk("wr_resp", got, model(p));
    chk("wr_data0", 69'(got[31:0]), 69'(0));
    chk("wr_flag", 69'(got[66]), 69'(1));
    chk("wr_lat", 69'(lat), 69'(2));
    chk("wr_no_spi", 69'(spi_txn - t0), 69'(0));

    // Pass-through: out-of-window request and a response packet
    t0 = spi_txn;
    p = mk(1'b1, 1'b0, 6'($urandom_range(0, 63)), 4'hF, 24'h0E0000, 2'($urandom_range(0, 3)), 32'($urandom));
    do_txn(p, lat, got, fo, fb);
    chk("pass_req", got, p);
    chk("pass_req_lat", 69'(lat), 69'(1));
    p = mk(1'b0, 1'b0, 6'($urandom_range(0, 63)), 4'hF, 24'hC00040, 2'($urandom_range(0, 3)), 32'($urandom));
    do_txn(p, lat, got, fo, fb);
    chk("pass_resp", got, p);
    chk("pass_resp_lat", 69'(lat), 69'(1));
    chk("pass_no_spi", 69'(spi_txn - t0), 69'(0));

    // Randomized reads anywhere in the window
    for (int n = 0; n < 3; n++) begin
      a = {2'b11, 22'($urandom)} & 24'hFFFFFC;
      p = mk(1'b1, 1'b0, 6'($urandom_range(0, 63)), 4'($urandom_range(0, 15)), a, 2'($urandom_range(0, 3)), 32'($urandom));
      do_txn(p, lat, got, fo, fb);
      chk("rnd_resp", got, model(p));
      chk("rnd_lat", 69'(lat), 69'(RD_LAT));
      chk("rnd_addr", 69'(spi_addr), 69'(a & ~WMASK));
    end

    // Second matching read while busy is forwarded untouched
    p = mk(1'b1, 1'b0, 6'($urandom_range(0, 63)), 4'hF, 24'hC00100, 2'($urandom_range(0, 3)), 32'($urandom));
    q = mk(1'b1, 1'b0, 6'($urandom_range(0, 63)), 4'hF, 24'hC00200, 2'($urandom_range(0, 3)), 32'($urandom));
    @(posedge clk); #1 rcn_in = p;
    @(posedge clk); #1 rcn_in = '0;
    t0 = spi_txn;
    lat = 1;
    repeat (10) @(posedge clk);
    #1 rcn_in = q;
    lat += 10;
    @(posedge clk); #1;
    lat++;
    chk("busy_fwd", rcn_out, q);
    chk("busy_held", 69'(busy), 69'(1));
    rcn_in = '0;
    wait_resp(lat, got);
    chk("busy_resp", got, model(p));
    chk("busy_lat", 69'(lat), 69'(RD_LAT));
    repeat (5) @(posedge clk);
    #1;
    chk("busy_one_txn", 69'(spi_txn - t0), 69'(1));

    // Response held while the slot is occupied for 5 cycles
    p = mk(1'b1, 1'b1, 6'($urandom_range(0, 63)), 4'hF, 24'hC00020, 2'($urandom_range(0, 3)), 32'($urandom));
    for (int i = 0; i < 5; i++)
      traffic[i] = mk(1'b0, 1'b0, 6'($urandom_range(0, 63)), 4'hF, {2'b00, 22'($urandom)}, 2'($urandom_range(0, 3)), 32'($urandom));
    traffic[2] = mk(1'b1, 1'b0, 6'($urandom_range(0, 63)), 4'hF, 24'hC00300, 2'($urandom_range(0, 3)), 32'($urandom));
    t0 = spi_txn;
    @(posedge clk); #1 rcn_in = p;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      rcn_in = traffic[i];
      if (i > 0) chk("slot_fwd", rcn_out, traffic[i - 1]);
    end
    @(posedge clk); #1;
    chk("slot_fwd_last", rcn_out, traffic[4]);
    chk("slot_busy", 69'(busy), 69'(1));
    rcn_in = '0;
    @(posedge clk); #1;
    chk("slot_insert", rcn_out, model(p));
    chk("slot_busy_clr", 69'(busy), 69'(0));
    repeat (4) @(posedge clk);
    #1;
    chk("slot_no_spi", 69'(spi_txn - t0), 69'(0));

    // Reset in the middle of a read
    p = mk(1'b1, 1'b0, 6'($urandom_range(0, 63)), 4'hF, 24'hC00010, 2'($urandom_range(0, 3)), 32'($urandom));
    @(posedge clk); #1 rcn_in = p;
    @(posedge clk); #1 rcn_in = '0;
    begin
      bit hit20;
      hit20 = 1'b0;
      for (int i = 0; i < 500 && !hit20; i++) begin
        @(negedge clk); #1;
        hit20 = (rise_cnt == 20);
      end
      chk("rst_mid_reached", 69'(hit20), 69'(1));
    end
    rst_n = 1'b0;
    #1;
    chk("rst_mid_csn", 69'(qspi_csn), 69'(1));
    chk("rst_mid_oe", 69'(qspi_io_oe), 69'(0));
    chk("rst_mid_busy", 69'(busy), 69'(0));
    chk("rst_mid_sck", 69'(qspi_clk), 69'(0));
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    begin
      bit stray;
      stray = 1'b0;
      for (int i = 0; i < 250; i++) begin
        @(posedge clk); #1;
        if (rcn_out[68]) stray = 1'b1;
      end
      chk("rst_mid_dropped", 69'(stray), 69'(0));
    end
    a = {2'b11, 22'($urandom)} & 24'hFFFFFC;
    p = mk(1'b1, 1'b0, 6'($urandom_range(0, 63)), 4'hF, a, 2'($urandom_range(0, 3)), 32'($urandom));
    t0 = spi_txn;
    do_txn(p, lat, got, fo, fb);
    chk("post_rst_resp", got, model(p));
    chk("post_rst_lat", 69'(lat), 69'(RD_LAT));
    chk("post_rst_txn", 69'(spi_txn - t0), 69'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
